// File: rtl/game_state_engine_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// game_state_engine_if : control inputs and renderer-facing status of the game
// logic stage.                                                   Rev 1.0
// ---------------------------------------------------------------------------
interface game_state_engine_if #(
  parameter int N_OBS = 5
);
  logic                 frame_tick;
  logic                 move_left;
  logic                 move_right;
  logic                 restart;
  logic [9:0]           ship_x;
  logic [N_OBS*11-1:0]  obs_y_flat;
  logic [1:0]           lives;
  logic                 game_over;
  logic                 invuln;
  logic                 hit_pulse;

  modport master (
    output frame_tick, move_left, move_right, restart,
    input  ship_x, obs_y_flat, lives, game_over, invuln, hit_pulse
  );

  modport slave (
    input  frame_tick, move_left, move_right, restart,
    output ship_x, obs_y_flat, lives, game_over, invuln, hit_pulse
  );
endinterface
`default_nettype wire

// File: rtl/game_state_engine.sv
`default_nettype none
// ---------------------------------------------------------------------------
// game_state_engine : per-frame obstacle/ship update, collision, lives FSM.
//                                                                Rev 1.0
// ---------------------------------------------------------------------------
module game_state_engine #(
  parameter int N_OBS         = 5,
  parameter int OBS_X_BASE    = 20,
  parameter int OBS_X_STEP    = 40,
  parameter int OBS_W         = 20,
  parameter int OBS_H         = 20,
  parameter int OBS_SPEED     = 5,
  parameter int OBS_STAGGER   = 120,
  parameter int SHIP_Y        = 440,
  parameter int SHIP_W        = 20,
  parameter int SHIP_H        = 20,
  parameter int SHIP_SPEED    = 2,
  parameter int PLAY_W        = 376,
  parameter int SCREEN_H      = 600,
  parameter int INVULN_FRAMES = 60,
  parameter int LIVES_INIT    = 3
) (
  input  wire logic         clk,
  input  wire logic         reset_n,
  game_state_engine_if.slave bus
);

  localparam int CNT_W = $clog2(INVULN_FRAMES + 1);

  localparam logic [10:0] c_ship_max  = 11'(PLAY_W - SHIP_W);
  localparam logic [9:0]  c_ship_rst  = 10'((PLAY_W - SHIP_W) / 2);
  localparam logic [9:0]  c_ship_step = 10'(SHIP_SPEED);
  localparam logic [10:0] c_obs_wrap  = 11'(SCREEN_H + OBS_H);
  localparam logic [10:0] c_obs_step  = 11'(OBS_SPEED);
  localparam logic [10:0] c_y_lo      = 11'(SHIP_Y);
  // y is the obstacle bottom edge, so y-OBS_H < SHIP_Y+SHIP_H becomes y < SHIP_Y+SHIP_H+OBS_H
  localparam logic [10:0] c_y_hi      = 11'(SHIP_Y + SHIP_H + OBS_H);

  typedef enum logic [1:0] {
    S_PLAY      = 2'd0,
    S_HIT       = 2'd1,
    S_GAME_OVER = 2'd2
  } state_t;

  state_t                r_state;
  logic [9:0]            r_ship_x;
  logic [10:0]           r_obs_y [N_OBS];
  logic [1:0]            r_lives;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_invuln;
  logic                  r_game_over;
  logic                  r_hit_pulse;

  logic [10:0]           w_ship11;
  logic [10:0]           w_ship_plus;
  logic [9:0]            w_ship_next;
  logic [N_OBS-1:0]      w_coll;
  logic [10:0]           w_obs_next [N_OBS];
  logic [N_OBS*11-1:0]   w_obs_flat;
  logic                  w_hit;
  logic                  w_restart;

  assign w_ship11    = {1'b0, r_ship_x};
  assign w_ship_plus = w_ship11 + 11'(SHIP_SPEED);
  assign w_hit       = |w_coll;
  assign w_restart   = bus.restart && (r_state == S_GAME_OVER);

  always_comb begin
    w_ship_next = r_ship_x;
    if (bus.move_left && !bus.move_right) begin
      if (r_ship_x < c_ship_step) w_ship_next = '0;
      else                        w_ship_next = r_ship_x - c_ship_step;
    end else if (bus.move_right && !bus.move_left) begin
      if (w_ship_plus > c_ship_max) w_ship_next = c_ship_max[9:0];
      else                          w_ship_next = w_ship_plus[9:0];
    end
  end

  for (genvar gi = 0; gi < N_OBS; gi++) begin : g_obs
    localparam logic [10:0] c_ox     = 11'(OBS_X_BASE + gi * OBS_X_STEP);
    localparam logic [10:0] c_ox_end = 11'(OBS_X_BASE + gi * OBS_X_STEP + OBS_W);
    logic [10:0] w_y_plus;

    assign w_y_plus       = r_obs_y[gi] + c_obs_step;
    assign w_obs_next[gi] = (w_y_plus >= c_obs_wrap) ? 11'd0 : w_y_plus;
    assign w_coll[gi]     = (w_ship11 < c_ox_end) &&
                            (c_ox < w_ship11 + 11'(SHIP_W)) &&
                            (r_obs_y[gi] > c_y_lo) &&
                            (r_obs_y[gi] < c_y_hi);
    assign w_obs_flat[11*gi +: 11] = r_obs_y[gi];
  end

  always_ff @(posedge clk) begin
    r_hit_pulse <= 1'b0;
    if (!reset_n || w_restart) begin
      r_state     <= S_PLAY;
      r_ship_x    <= c_ship_rst;
      r_lives     <= 2'(LIVES_INIT);
      r_cnt       <= '0;
      r_invuln    <= 1'b0;
      r_game_over <= 1'b0;
      for (int i = 0; i < N_OBS; i++) begin
        r_obs_y[i] <= 11'(i * OBS_STAGGER);
      end
    end else if (bus.frame_tick) begin
      if (r_state != S_GAME_OVER) begin
        r_ship_x <= w_ship_next;
        for (int i = 0; i < N_OBS; i++) begin
          r_obs_y[i] <= w_obs_next[i];
        end
      end
      case (r_state)
        S_PLAY: begin
          if (w_hit) begin
            r_hit_pulse <= 1'b1;
            r_lives     <= r_lives - 2'd1;
            if (r_lives == 2'd1) begin
              r_state     <= S_GAME_OVER;
              r_game_over <= 1'b1;
            end else begin
              r_state  <= S_HIT;
              r_invuln <= 1'b1;
              r_cnt    <= CNT_W'(INVULN_FRAMES);
            end
          end
        end
        S_HIT: begin
          if (r_cnt == CNT_W'(1)) begin
            r_state  <= S_PLAY;
            r_invuln <= 1'b0;
            r_cnt    <= '0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_GAME_OVER: begin
          r_state <= S_GAME_OVER;
        end
        default: begin
          r_state <= S_PLAY;
        end
      endcase
    end
  end

  assign bus.ship_x     = r_ship_x;
  assign bus.obs_y_flat = w_obs_flat;
  assign bus.lives      = r_lives;
  assign bus.game_over  = r_game_over;
  assign bus.invuln     = r_invuln;
  assign bus.hit_pulse  = r_hit_pulse;

endmodule
`default_nettype wire

// File: tb/tb_game_state_engine.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_game_state_engine : table-driven frame sequences with a scoreboard queue.
//                                                                Rev 1.0
// ---------------------------------------------------------------------------
module tb_game_state_engine;

  localparam int N_OBS   = 5;
  localparam int NV      = 17;

  logic clk = 1'b0;
  logic reset_n;

  always #10 clk = ~clk;

  game_state_engine_if #(.N_OBS(N_OBS)) bus ();

  game_state_engine #(.N_OBS(N_OBS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    bit rst;
    int ticks;
    bit ml;
    bit mr;
    bit rs;
    int frames;
    int ship;
    int lives;
    bit go;
    bit inv;
    bit hp;
  } vec_t;

  typedef struct {
    int tag;
    int frames;
    int ship;
    int lives;
    bit go;
    bit inv;
    bit hp;
  } exp_t;

  vec_t vec [NV];
  exp_t sb_q [$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   max_ship = 0;

  // Obstacles fall 5 px/frame through a 620 px cycle starting at i*120
  function automatic int obs_model(input int i, input int frames);
    return (i * 120 + frames * 5) % 620;
  endfunction

  function automatic exp_t mk_exp(input int tag, input int frames, input int ship,
                                  input int lives, input bit go, input bit inv, input bit hp);
    exp_t e;
    e.tag = tag; e.frames = frames; e.ship = ship; e.lives = lives;
    e.go = go; e.inv = inv; e.hp = hp;
    return e;
  endfunction

  task automatic cmp(input int tag, input string what, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s [step %0d]: got %0d, expected %0d", what, tag, act, exp);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_empty: got 0 entries, expected 1");
      return;
    end
    e = sb_q.pop_front();
    cmp(e.tag, "ship_x", int'(bus.ship_x), e.ship);
    for (int i = 0; i < N_OBS; i++) begin
      cmp(e.tag, $sformatf("obs_y%0d", i), int'(bus.obs_y_flat[11*i +: 11]), obs_model(i, e.frames));
    end
    cmp(e.tag, "lives", int'(bus.lives), e.lives);
    cmp(e.tag, "game_over", int'(bus.game_over), int'(e.go));
    cmp(e.tag, "invuln", int'(bus.invuln), int'(e.inv));
    cmp(e.tag, "hit_pulse", int'(bus.hit_pulse), int'(e.hp));
  endtask

  task automatic note_ship();
    if (int'(bus.ship_x) > max_ship) max_ship = int'(bus.ship_x);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.frame_tick = 1'b0; bus.move_left = 1'b0; bus.move_right = 1'b0; bus.restart = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic do_tick(input bit ml, input bit mr, input bit rs);
    bus.frame_tick = 1'b1; bus.move_left = ml; bus.move_right = mr; bus.restart = rs;
    @(negedge clk);
    bus.frame_tick = 1'b0; bus.move_left = 1'b0; bus.move_right = 1'b0; bus.restart = 1'b0;
    note_ship();
  endtask

  initial begin
    //         rst ticks ml mr rs frames ship lives go inv hp
    vec[0]  = '{1,    0, 0, 0, 0,    0, 178, 3, 0, 0, 0};
    vec[1]  = '{0,    1, 0, 0, 0,    1, 178, 3, 0, 0, 0};
    vec[2]  = '{1,    1, 0, 1, 0,    1, 180, 3, 0, 0, 0};
    vec[3]  = '{0,   88, 0, 1, 0,   89, 356, 3, 0, 0, 0};
    vec[4]  = '{0,  111, 0, 1, 0,  200, 356, 3, 0, 0, 0};
    // leftward sweep from reset takes one hit (obstacle 3) on frame 18
    vec[5]  = '{1,  100, 1, 0, 0,  100,   0, 2, 0, 0, 0};
    vec[6]  = '{0,  100, 1, 0, 0,  200,   0, 2, 0, 0, 0};
    vec[7]  = '{1,  117, 0, 0, 0,  117, 178, 3, 0, 0, 0};
    vec[8]  = '{0,    1, 0, 0, 0,  118, 178, 2, 0, 1, 1};
    vec[9]  = '{0,    0, 0, 0, 0,  118, 178, 2, 0, 1, 0};
    vec[10] = '{0,   59, 0, 0, 0,  177, 178, 2, 0, 1, 0};
    vec[11] = '{0,    1, 0, 0, 0,  178, 178, 2, 0, 0, 0};
    vec[12] = '{0,   64, 0, 0, 0,  242, 178, 1, 0, 1, 1};
    vec[13] = '{0,  124, 0, 0, 0,  366, 178, 0, 1, 0, 1};
    vec[14] = '{0,   10, 0, 1, 0,  366, 178, 0, 1, 0, 0};
    vec[15] = '{0,    1, 0, 0, 1,    0, 178, 3, 0, 0, 0};
    vec[16] = '{0,    1, 0, 0, 1,    1, 178, 3, 0, 0, 0};

    reset_n = 1'b0;
    bus.frame_tick = 1'b0; bus.move_left = 1'b0; bus.move_right = 1'b0; bus.restart = 1'b0;
    @(negedge clk);
    @(negedge clk);

    for (int r = 0; r < NV; r++) begin
      if (vec[r].rst) do_reset();
      sb_q.push_back(mk_exp(r, vec[r].frames, vec[r].ship, vec[r].lives,
                            vec[r].go, vec[r].inv, vec[r].hp));
      if (vec[r].ticks == 0) begin
        @(negedge clk);
        note_ship();
      end
      for (int t = 0; t < vec[r].ticks; t++) begin
        do_tick(vec[r].ml, vec[r].mr, vec[r].rs);
      end
      check_out();
    end

    // Reset asserted in the middle of invulnerability, coinciding with a tick
    do_reset();
    for (int t = 0; t < 148; t++) do_tick(1'b0, 1'b0, 1'b0);
    sb_q.push_back(mk_exp(100, 148, 178, 2, 1'b0, 1'b1, 1'b0));
    check_out();
    reset_n = 1'b0;
    bus.frame_tick = 1'b1; bus.move_right = 1'b1;
    sb_q.push_back(mk_exp(101, 0, 178, 3, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    reset_n = 1'b1;
    bus.frame_tick = 1'b0; bus.move_right = 1'b0;
    note_ship();
    check_out();

    cmp(102, "ship_x_peak", max_ship, 356);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
